// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matmul row engine.
// Build option MATMUL_SAT_EN switches the dot product to full-precision
// accumulation with saturation; the default build wraps modulo 2^W.
package matmul_pkg;
    localparam int MM_N  = 16;
    localparam int MM_W  = 32;
    localparam int IDX_W = $clog2(MM_N);
    // full 2W products plus log2(N) bits of headroom for the adder tree
    localparam int ACC_W = 2*MM_W + IDX_W;

    typedef logic signed [MM_W-1:0] word_t;
    typedef word_t [MM_N-1:0] row_t;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, OUT, FIN} state_t;
endpackage

// File: rtl/matmul_row_engine_dot.sv
// dot_product_tree: combinational N-lane multiply plus balanced adder tree.
// Under MATMUL_SAT_EN the products stay at 2W bits, the tree is widened by
// log2(N) bits and the final sum is clamped to the signed W-bit range.
module dot_product_tree #(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic [N*W-1:0] a_row,
    input  logic [N*W-1:0] b_row,
    output logic [W-1:0]   dot
);
`ifdef MATMUL_SAT_EN
    localparam int AW = 2*W + $clog2(N);
    localparam int PW = 2*W;
`else
    localparam int AW = W;
`endif

    // heap-ordered tree: leaves at N-1..2N-2, node n = node 2n+1 + node 2n+2
    logic signed [AW-1:0] node [2*N-1];

    for (genvar k = 0; k < N; k++) begin : g_mul
        logic signed [W-1:0] av, bv;
        assign av = a_row[k*W +: W];
        assign bv = b_row[k*W +: W];
`ifdef MATMUL_SAT_EN
        logic signed [PW-1:0] prod;
        assign prod = PW'(av) * PW'(bv);
        assign node[N-1+k] = AW'(prod);
`else
        assign node[N-1+k] = av * bv;
`endif
    end

    for (genvar n = 0; n < N-1; n++) begin : g_add
        assign node[n] = node[2*n+1] + node[2*n+2];
    end

`ifdef MATMUL_SAT_EN
    localparam logic signed [AW-1:0] SMAX = AW'($signed({1'b0, {(W-1){1'b1}}}));
    localparam logic signed [AW-1:0] SMIN = AW'($signed({1'b1, {(W-1){1'b0}}}));

    // clamp the exact sum into the signed W-bit range
    always_comb begin
        dot = node[0][W-1:0];
        if (node[0] > SMAX)
            dot = SMAX[W-1:0];
        else if (node[0] < SMIN)
            dot = SMIN[W-1:0];
    end
`else
    // wrap mode: the tree already works modulo 2^W
    always_comb begin
        dot = node[0];
    end
`endif
endmodule

// File: rtl/matmul_row_engine.sv
// matmul_row_engine: sequences A/B row reads from the register file, forms
// C[i][j] = dot(A row i, B row j) and streams results row-major over a
// valid/ready handshake. MATMUL_SAT_EN selects saturating arithmetic.
module matmul_row_engine
    import matmul_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 32
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [$clog2(N)-1:0] SEQ_A,
    output logic [$clog2(N)-1:0] SEQ_B,
    output logic                 MATAB_MUX,
    input  logic [N*W-1:0]       MAT_IN,
    output logic [W-1:0]         RES_DATA,
    output logic [$clog2(N)-1:0] RES_ROW,
    output logic [$clog2(N)-1:0] RES_COL,
    output logic                 RES_VALID,
    input  logic                 RES_READY
);
    localparam int IW = $clog2(N);

    state_t          state, state_n;
    logic [IW-1:0]   i, j;
    logic [N*W-1:0]  a_buf, b_buf;
    logic [W-1:0]    dot;
    logic            last_i, last_j, accept;

    assign SEQ_A  = i;
    assign SEQ_B  = j;
    assign last_i = (i == IW'(N-1));
    assign last_j = (j == IW'(N-1));
    assign accept = RES_VALID && RES_READY;

    dot_product_tree #(.N(N), .W(W)) u_dot (
        .a_row (a_buf),
        .b_row (b_buf),
        .dot   (dot)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (!RSTN)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next-state: A row reused across a row, reloaded only on row change
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (START) state_n = LOAD_A;
            LOAD_A:  state_n = LOAD_B;
            LOAD_B:  state_n = CALC;
            CALC:    state_n = OUT;
            OUT: begin
                if (accept) begin
                    if (!last_j)      state_n = LOAD_B;
                    else if (!last_i) state_n = LOAD_A;
                    else              state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // counters, row buffers, registered selects and result/handshake outputs
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            i         <= '0;
            j         <= '0;
            a_buf     <= '0;
            b_buf     <= '0;
            MATAB_MUX <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            RES_DATA  <= '0;
            RES_ROW   <= '0;
            RES_COL   <= '0;
            RES_VALID <= 1'b0;
        end else begin
            DONE      <= 1'b0;
            // select is registered so the register file sees it in LOAD_A itself
            MATAB_MUX <= (state_n == LOAD_A);
            case (state)
                IDLE: begin
                    if (START) begin
                        i    <= '0;
                        j    <= '0;
                        BUSY <= 1'b1;
                    end
                end
                LOAD_A: a_buf <= MAT_IN;
                LOAD_B: b_buf <= MAT_IN;
                CALC: begin
                    RES_DATA  <= dot;
                    RES_ROW   <= i;
                    RES_COL   <= j;
                    RES_VALID <= 1'b1;
                end
                OUT: begin
                    if (accept) begin
                        RES_VALID <= 1'b0;
                        if (!last_j) begin
                            j <= j + IW'(1);
                        end else if (!last_i) begin
                            i <= i + IW'(1);
                            j <= '0;
                        end
                    end
                end
                FIN: begin
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
